// File: rtl/acc_sat_pkg.sv
// ============================================================================
// Module : acc_sat_pkg
// Brief  : Shared round-half-up / signed-saturate helpers for arithmetic back ends.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package acc_sat_pkg;

   // Working width for the rounding add; callers need ACC_WIDTH < SAT_MAXW.
   localparam int SAT_MAXW    = 64;
   localparam int DEF_WIDTH_O = 32;

   typedef struct packed {
      logic signed [SAT_MAXW-1:0] data;
      logic                       sat;
   } sat_res_t;

   function automatic logic signed [SAT_MAXW-1:0] out_max(input int wo);
      return (64'sd1 <<< (wo - 1)) - 64'sd1;
   endfunction

   function automatic logic signed [SAT_MAXW-1:0] out_min(input int wo);
      return -(64'sd1 <<< (wo - 1));
   endfunction

   function automatic sat_res_t round_sat(input logic signed [SAT_MAXW-1:0] s,
                                          input int shift, input int wo);
      sat_res_t                   res;
      logic signed [SAT_MAXW-1:0] bias;
      logic signed [SAT_MAXW-1:0] r;
      bias = (shift > 0) ? (64'sd1 <<< (shift - 1)) : 64'sd0;
      r    = (s + bias) >>> shift;
      res.data = r;
      res.sat  = 1'b0;
      if (r > out_max(wo)) begin
         res.data = out_max(wo);
         res.sat  = 1'b1;
      end else if (r < out_min(wo)) begin
         res.data = out_min(wo);
         res.sat  = 1'b1;
      end
      return res;
   endfunction

   localparam logic signed [SAT_MAXW-1:0] OUT_MAX = out_max(DEF_WIDTH_O);
   localparam logic signed [SAT_MAXW-1:0] OUT_MIN = out_min(DEF_WIDTH_O);

endpackage

`default_nettype wire

// File: rtl/tag_delay_line.sv
// ============================================================================
// Module : tag_delay_line
// Brief  : Fixed-depth shift register for sideband tags; bit 0 of each stage is tapped.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tag_delay_line #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [DEPTH-1:0] lsb_taps
);

   logic [WIDTH-1:0] r_stage [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stage <= '{default: '0};
      end else begin
         r_stage[0] <= din;
         for (int i = 1; i < DEPTH; i++) begin
            r_stage[i] <= r_stage[i-1];
         end
      end
   end

   genvar g;
   for (g = 0; g < DEPTH; g++) begin : g_tap
      assign lsb_taps[g] = r_stage[g][0];
   end

   assign dout = r_stage[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/signed_prod_accum.sv
// ============================================================================
// Module : signed_prod_accum
// Brief  : Frame accumulator for signed multiplier products with rounded, saturated output.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module signed_prod_accum
   import acc_sat_pkg::*;
#(
   parameter int WIDTH_P     = 29,
   parameter int LATENCY     = 6,
   parameter int ACC_WIDTH   = 40,
   parameter int ROUND_SHIFT = 0,
   parameter int WIDTH_O     = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   input  logic                      in_first,
   input  logic                      in_last,
   input  logic signed [WIDTH_P-1:0] prod,
   output logic                      out_valid,
   output logic signed [WIDTH_O-1:0] out_data,
   output logic                      out_sat,
   output logic                      frame_err,
   output logic                      busy
);

   if (LATENCY < 1 || ACC_WIDTH < WIDTH_P || ROUND_SHIFT < 0 ||
       ROUND_SHIFT > ACC_WIDTH - WIDTH_O || ACC_WIDTH >= SAT_MAXW) begin : g_param_check
      $error("signed_prod_accum: illegal parameter combination");
   end

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_ACCUM = 1'b1
   } state_t;

   state_t                        r_state, w_state_nxt;
   logic signed [ACC_WIDTH-1:0]   r_acc, w_acc_nxt;
   logic                          r_out_valid, r_out_sat, r_frame_err;
   logic signed [WIDTH_O-1:0]     r_out_data;
   logic                          w_emit, w_err;
   logic [2:0]                    w_tag_in, w_tag_d;
   logic [LATENCY-1:0]            w_valid_taps;
   logic                          w_d_valid, w_d_first, w_d_last;
   logic signed [ACC_WIDTH-1:0]   w_sext;
   sat_res_t                      w_res;
   logic [SAT_MAXW-WIDTH_O-1:0]   w_unused_hi;

   // Tag bit 0 is valid so the delay line can expose per-stage valid for busy.
   assign w_tag_in = {in_last, in_first, in_valid};

   tag_delay_line #(
      .WIDTH (3),
      .DEPTH (LATENCY)
   ) u_tag_delay (
      .clk      (clk),
      .rst      (rst),
      .din      (w_tag_in),
      .dout     (w_tag_d),
      .lsb_taps (w_valid_taps)
   );

   assign w_d_valid = w_tag_d[0];
   assign w_d_first = w_tag_d[1];
   assign w_d_last  = w_tag_d[2];
   assign w_sext    = ACC_WIDTH'(prod);

   always_comb begin
      w_state_nxt = r_state;
      w_acc_nxt   = r_acc;
      w_emit      = 1'b0;
      w_err       = 1'b0;
      if (w_d_valid) begin
         case (r_state)
            ST_IDLE: begin
               w_acc_nxt = w_sext;
               if (w_d_last) w_emit = 1'b1;
               else          w_state_nxt = ST_ACCUM;
            end
            ST_ACCUM: begin
               if (w_d_first) begin
                  w_err     = 1'b1;
                  w_acc_nxt = w_sext;
               end else begin
                  w_acc_nxt = r_acc + w_sext;
               end
               if (w_d_last) begin
                  w_emit      = 1'b1;
                  w_state_nxt = ST_IDLE;
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // Rounding runs on the next-acc value so the result registers alongside acc.
   assign w_res       = round_sat(SAT_MAXW'(w_acc_nxt), ROUND_SHIFT, WIDTH_O);
   assign w_unused_hi = w_res.data[SAT_MAXW-1:WIDTH_O];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_acc       <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_sat   <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_acc       <= w_acc_nxt;
         r_out_valid <= w_emit;
         r_frame_err <= w_err;
         if (w_emit) begin
            r_out_data <= w_res.data[WIDTH_O-1:0];
            r_out_sat  <= w_res.sat;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_sat   = r_out_sat;
   assign frame_err = r_frame_err;
   assign busy      = (r_state == ST_ACCUM) | (|w_valid_taps);

endmodule

`default_nettype wire

// File: tb/tb_signed_prod_accum.sv
// ============================================================================
// Module : tb_signed_prod_accum
// Brief  : Directed bench: multiplier model feeding three accumulator configurations.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_signed_prod_accum;

   typedef struct {
      int                 cyc;
      logic signed [31:0] data;
      logic               sat;
   } rec_t;

   logic               clk = 1'b0;
   logic               rst;
   logic               in_valid, in_first, in_last;
   logic signed [15:0] a;
   logic signed [12:0] b;
   logic signed [28:0] pipe [6];
   logic signed [28:0] prod;

   logic               ov_m, os_m, fe_m, busy_m;
   logic signed [31:0] od_m;
   logic               ov_16, os_16, fe_16, busy_16;
   logic signed [15:0] od_16;
   logic               ov_r, os_r, fe_r, busy_r;
   logic signed [31:0] od_r;

   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   int   drv_cyc, t_mark;
   rec_t q_m[$], q_16[$], q_r[$];
   int   q_err[$];
   int   exp_r [4];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Multiplier model with 6-cycle latency.
   always @(posedge clk) begin
      pipe[0] <= a * b;
      for (int i = 1; i < 6; i++) pipe[i] <= pipe[i-1];
   end
   assign prod = pipe[5];

   signed_prod_accum #(.WIDTH_P(29), .LATENCY(6), .ACC_WIDTH(40), .ROUND_SHIFT(0), .WIDTH_O(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
      .prod(prod), .out_valid(ov_m), .out_data(od_m), .out_sat(os_m), .frame_err(fe_m), .busy(busy_m));

   signed_prod_accum #(.WIDTH_P(29), .LATENCY(6), .ACC_WIDTH(40), .ROUND_SHIFT(0), .WIDTH_O(16)) dut16 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
      .prod(prod), .out_valid(ov_16), .out_data(od_16), .out_sat(os_16), .frame_err(fe_16), .busy(busy_16));

   signed_prod_accum #(.WIDTH_P(29), .LATENCY(6), .ACC_WIDTH(40), .ROUND_SHIFT(2), .WIDTH_O(32)) dutr (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
      .prod(prod), .out_valid(ov_r), .out_data(od_r), .out_sat(os_r), .frame_err(fe_r), .busy(busy_r));

   always @(negedge clk) begin
      if (ov_m)  q_m.push_back('{cyc, od_m, os_m});
      if (ov_16) q_16.push_back('{cyc, {{16{od_16[15]}}, od_16}, os_16});
      if (ov_r)  q_r.push_back('{cyc, od_r, os_r});
      if (fe_m)  q_err.push_back(cyc);
   end

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic send(input int av, input int bv, input logic f, input logic l);
      a        = 16'(av);
      b        = 13'(bv);
      in_valid = 1'b1;
      in_first = f;
      in_last  = l;
      drv_cyc  = cyc;
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      in_first = 1'b0;
      in_last  = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic clear_q();
      q_m.delete(); q_16.delete(); q_r.delete(); q_err.delete();
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; a = '0; b = '0;
      repeat (8) @(posedge clk);
      #1;
      chk("rst_valid", ov_m, 0);
      chk("rst_data", od_m, 0);
      chk("rst_sat", os_m, 0);
      chk("rst_ferr", fe_m, 0);
      chk("rst_busy", {busy_m, busy_16, busy_r, fe_16, fe_r}, 0);
      rst = 1'b0;
      idle(2);

      // Frame {3*2, -4*7, 5*-1} = -27, latency 7 from last
      clear_q();
      send(3, 2, 1, 0);
      chk("t1_busy_start", busy_m, 1);
      send(-4, 7, 0, 0);
      send(5, -1, 0, 1);
      t_mark = drv_cyc;
      idle(12);
      chk("t1_count", q_m.size(), 1);
      if (q_m.size() > 0) begin
         chk("t1_data", q_m[0].data, -27);
         chk("t1_sat", q_m[0].sat, 0);
         chk("t1_latency", q_m[0].cyc - t_mark, 7);
      end
      chk("t1_busy_end", busy_m, 0);
      chk("t1_no_ferr", q_err.size(), 0);

      // Single-product frames every cycle
      clear_q();
      for (int i = 0; i < 5; i++) send(-32768, -4096, 1, 1);
      idle(12);
      chk("t2_count", q_m.size(), 5);
      for (int i = 0; i < q_m.size(); i++) begin
         chk("t2_data", q_m[i].data, 134217728);
         chk("t2_gapless", q_m[i].cyc - q_m[0].cyc, i);
      end
      chk("t2_no_ferr", q_err.size(), 0);
      chk("t2_w16_count", q_16.size(), 5);
      if (q_16.size() > 0) begin
         chk("t2_w16_data", q_16[0].data, 32767);
         chk("t2_w16_sat", q_16[0].sat, 1);
      end
      if (q_r.size() > 0) chk("t2_rs_data", q_r[0].data, 33554432);

      // Positive then negative saturation at 16-bit output
      clear_q();
      for (int i = 0; i < 4; i++) send(32767, 4095, i == 0, i == 3);
      for (int i = 0; i < 4; i++) send(-32768, 4095, i == 0, i == 3);
      idle(12);
      chk("t3_count", q_16.size(), 2);
      if (q_16.size() > 1) begin
         chk("t3_pos_data", q_16[0].data, 32767);
         chk("t3_pos_sat", q_16[0].sat, 1);
         chk("t3_neg_data", q_16[1].data, -32768);
         chk("t3_neg_sat", q_16[1].sat, 1);
      end
      chk("t3_w32_count", q_m.size(), 2);
      if (q_m.size() > 1) begin
         chk("t3_w32_pos", q_m[0].data, 536723460);
         chk("t3_w32_pos_sat", q_m[0].sat, 0);
         chk("t3_w32_neg", q_m[1].data, -536739840);
      end

      // Round half up with ROUND_SHIFT=2
      clear_q();
      exp_r = '{2, 1, -1, -2};
      send(6, 1, 1, 1);
      send(5, 1, 1, 1);
      send(-6, 1, 1, 1);
      send(-7, 1, 1, 1);
      idle(12);
      chk("t4_count", q_r.size(), 4);
      for (int i = 0; i < q_r.size() && i < 4; i++) begin
         chk("t4_round", q_r[i].data, exp_r[i]);
         chk("t4_sat", q_r[i].sat, 0);
      end

      // Restart mid-frame: frame_err and restarted sum only
      clear_q();
      send(10, 1, 1, 0);
      send(20, 1, 0, 0);
      send(7, 3, 1, 0);
      t_mark = drv_cyc;
      send(1, 1, 0, 1);
      idle(12);
      chk("t5_ferr_count", q_err.size(), 1);
      if (q_err.size() > 0) chk("t5_ferr_time", q_err[0] - t_mark, 7);
      chk("t5_count", q_m.size(), 1);
      if (q_m.size() > 0) chk("t5_data", q_m[0].data, 22);

      // Reset 3 cycles after last drops the frame
      clear_q();
      send(100, 1, 1, 0);
      send(200, 1, 0, 1);
      idle(2);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("t6_busy", busy_m, 0);
      chk("t6_valid", ov_m, 0);
      chk("t6_data", od_m, 0);
      chk("t6_sat", os_m, 0);
      chk("t6_ferr", fe_m, 0);
      rst = 1'b0;
      idle(12);
      chk("t6_dropped", q_m.size(), 0);
      send(2, 3, 1, 0);
      send(4, 5, 0, 1);
      idle(12);
      chk("t6_after_count", q_m.size(), 1);
      if (q_m.size() > 0) chk("t6_after_data", q_m[0].data, 26);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
